// File: rtl/button_conditioner_pkg.sv
// btn_pkg: shared definitions for the push-button conditioning chain.
//   btn_state_e             - 2-bit debounce FSM state
//   CLK_HZ                  - HFOSC frequency the cycle counts are derived from
//   DEBOUNCE_MS_DEFAULT     - default debounce window in milliseconds
//   LONG_MS_DEFAULT         - default long-press hold time in milliseconds
//   *_CYCLES_DEFAULT        - the above converted to clock cycles
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } btn_state_e;

  localparam int unsigned CLK_HZ              = 48_000_000;
  localparam int unsigned DEBOUNCE_MS_DEFAULT = 10;
  localparam int unsigned LONG_MS_DEFAULT     = 1000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = ms_to_cycles(DEBOUNCE_MS_DEFAULT);
  localparam int unsigned LONG_CYCLES_DEFAULT     = ms_to_cycles(LONG_MS_DEFAULT);

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser for asynchronous pad inputs.
//   clk  - destination clock
//   rst  - asynchronous active-low reset, loads RESET_VAL into both flops
//   d    - asynchronous input
//   q    - synchronised output (two flops of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects the raw
// push-button pad.
//   clk       - system clock (HFOSC)
//   rst       - asynchronous active-low reset
//   btn_in    - raw asynchronous pad input
//   pressed   - debounced level, 1 = button held
//   press_p   - one-cycle pulse on an accepted press
//   release_p - one-cycle pulse on an accepted release
//   long_p    - one-cycle pulse when a hold reaches LONG_CYCLES
// Build option: define BUTTON_LONG_PRESS_EN to include the hold counter and
// long_p; without it long_p is constant 0 and all other timing is unchanged.
module button_conditioner
  import btn_pkg::*;
#(
  parameter bit          ACTIVE_HIGH     = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pressed,
  output logic press_p,
  output logic release_p,
  output logic long_p
);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_params
    $error("button_conditioner: DEBOUNCE_CYCLES and LONG_CYCLES must be at least 2");
  end

  localparam int unsigned    DW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]  DLAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q;
  logic          btn_s;
  btn_state_e    state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic          press_acc;
  logic          rel_acc;

  // Reset value is the inactive pad level so a held button never looks
  // pressed straight out of reset.
  sync_2ff #(
    .RESET_VAL (!ACTIVE_HIGH)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync_q)
  );

  assign btn_s = sync_q ^ ~ACTIVE_HIGH;

  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    press_acc = 1'b0;
    rel_acc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = ARM_PRESS;
          dcnt_n  = '0;
        end
      end
      ARM_PRESS: begin
        if (!btn_s) begin
          state_n = IDLE;
        end else if (dcnt == DLAST) begin
          state_n   = HELD;
          press_acc = 1'b1;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_n = ARM_RELEASE;
          dcnt_n  = '0;
        end
      end
      ARM_RELEASE: begin
        if (btn_s) begin
          state_n = HELD;
        end else if (dcnt == DLAST) begin
          state_n = IDLE;
          rel_acc = 1'b1;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dcnt      <= '0;
      pressed   <= 1'b0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
    end else begin
      state     <= state_n;
      dcnt      <= dcnt_n;
      press_p   <= press_acc;
      release_p <= rel_acc;
      if (press_acc) begin
        pressed <= 1'b1;
      end else if (rel_acc) begin
        pressed <= 1'b0;
      end
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned   HW    = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HMAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HLAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hcnt;
  logic          in_hold;

  assign in_hold = (state == HELD) || (state == ARM_RELEASE);

  // The counter saturates at LONG_CYCLES, so HLAST is seen at most once per
  // press. A release completing on that same cycle wins over long_p.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt   <= '0;
      long_p <= 1'b0;
    end else begin
      long_p <= in_hold && (hcnt == HLAST) && !rel_acc;
      if (press_acc) begin
        hcnt <= '0;
      end else if (in_hold && (hcnt != HMAX)) begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end
`else
  assign long_p = 1'b0;
`endif

endmodule
